// File: rtl/cell_assembler.sv
// Purpose : gathers one opcode plus a raster-order pixel stream into the cellA/cellB matrices and presents them as one instruction.
// Latency : iw_valid rises on the edge after the final pixel is accepted (1 + CELL_DIM^2 cycles from command, 1 + 2*CELL_DIM^2 with load_b).
// Backpres: cmd_ready only in IDLE, pix_ready only in LOAD_A/LOAD_B; payload holds while iw_valid & !iw_ready.
//
// Ports:
//   clk, reset_n                     clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_opcode, cmd_load_b carried with it
//   pix_valid/pix_ready/pix_data     pixel stream handshake, raster order, cellA first then cellB
//   iw_valid/iw_ready                instruction handshake; iw_opcode, iw_cell_a, iw_cell_b payload
//   busy                             high whenever the assembler is not in IDLE
// Optional: define CELL_ASSEMBLER_PERF_EN to add perf_issue_cnt and perf_stall_cnt outputs.
module cell_assembler #(
  parameter int CELL_DIM = 4,
  parameter int PIXEL_W  = 24,
  parameter int OPCODE_W = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [OPCODE_W-1:0]                 cmd_opcode,
  input  logic                                cmd_load_b,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic [PIXEL_W-1:0]                  pix_data,
  output logic                                iw_valid,
  input  logic                                iw_ready,
  output logic [OPCODE_W-1:0]                 iw_opcode,
  output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0] iw_cell_a,
  output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0] iw_cell_b,
  output logic                                busy
`ifdef CELL_ASSEMBLER_PERF_EN
  ,
  output logic [31:0]                         perf_issue_cnt,
  output logic [31:0]                         perf_stall_cnt
`endif
);

  localparam int NPIX = CELL_DIM * CELL_DIM;
  localparam int CW   = (CELL_DIM > 1) ? $clog2(CELL_DIM) : 1;
  localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t                            state;
  logic [CW-1:0]                     row;
  logic [CW-1:0]                     col;
  logic                              load_b;
  logic [OPCODE_W-1:0]               opcode;
  // Packed so that element r*CELL_DIM+c lands at bits (r*CELL_DIM+c)*PIXEL_W.
  logic [NPIX-1:0][PIXEL_W-1:0]      cell_a;
  logic [NPIX-1:0][PIXEL_W-1:0]      cell_b;

  logic [IDXW-1:0]                   pix_idx;
  logic                              last_col;
  logic                              last_row;
  logic                              pix_take;

  assign pix_idx  = IDXW'(row) * IDXW'(CELL_DIM) + IDXW'(col);
  assign last_col = (col == CW'(CELL_DIM - 1));
  assign last_row = (row == CW'(CELL_DIM - 1));

  // Handshake outputs are pure decodes of the state register.
  assign cmd_ready = (state == IDLE);
  assign pix_ready = (state == LOAD_A) || (state == LOAD_B);
  assign iw_valid  = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign pix_take  = pix_ready && pix_valid;

  assign iw_opcode = opcode;
  assign iw_cell_a = cell_a;
  assign iw_cell_b = cell_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      load_b <= 1'b0;
      opcode <= '0;
      cell_a <= '0;
      cell_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            opcode <= cmd_opcode;
            load_b <= cmd_load_b;
            row    <= '0;
            col    <= '0;
            state  <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          if (pix_take) begin
            if (state == LOAD_A) cell_a[pix_idx] <= pix_data;
            else                 cell_b[pix_idx] <= pix_data;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                // cellB is only streamed when the command asked for it; otherwise the held cellB is reused.
                state <= (state == LOAD_A && load_b) ? LOAD_B : ISSUE;
              end else begin
                row <= row + CW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        ISSUE: begin
          if (iw_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CELL_ASSEMBLER_PERF_EN
  // Stall = consumer not taking a ready instruction, or source not offering a wanted pixel.
  logic perf_stall;
  assign perf_stall = (iw_valid && !iw_ready) || (pix_ready && !pix_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (iw_valid && iw_ready) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (perf_stall)           perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_assembler.sv
// Purpose : self-checking bench for cell_assembler (CELL_DIM=4) using a table of directed instructions plus random ones.
// Latency : checks iw_valid one edge after the last accepted pixel and the exact load cycle count without gaps.
// Backpres: exercises pixel gaps, iw_ready holds, and commands/pixels offered while they must not be accepted.
module tb_cell_assembler;

  localparam int D  = 4;
  localparam int N  = D * D;
  localparam int PW = 24;
  localparam int CB = N * PW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic          cmd_load_b;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_data;
  logic          iw_valid;
  logic          iw_ready;
  logic [3:0]    iw_opcode;
  logic [CB-1:0] iw_cell_a;
  logic [CB-1:0] iw_cell_b;
  logic          busy;
`ifdef CELL_ASSEMBLER_PERF_EN
  logic [31:0]   perf_issue_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  cell_assembler #(.CELL_DIM(D), .PIXEL_W(PW), .OPCODE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_load_b (cmd_load_b),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .iw_valid   (iw_valid),
    .iw_ready   (iw_ready),
    .iw_opcode  (iw_opcode),
    .iw_cell_a  (iw_cell_a),
    .iw_cell_b  (iw_cell_b),
    .busy       (busy)
`ifdef CELL_ASSEMBLER_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: matrices indexed [row][col], filled straight from the stream order.
  logic [PW-1:0] mdl_a [D][D];
  logic [PW-1:0] mdl_b [D][D];
  logic [3:0]    mdl_op;
  logic [PW-1:0] stim [2*N];

  typedef struct {
    logic [3:0]    op;
    bit            lb;
    logic [PW-1:0] a_base, a_step, b_base, b_step;
    int            stall, hold;
    logic [PW-1:0] exp_a0, exp_a15, exp_b0, exp_b15;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] pack_a();
    logic [CB-1:0] v = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        v[(r*D+c)*PW +: PW] = mdl_a[r][c];
    return v;
  endfunction

  function automatic logic [CB-1:0] pack_b();
    logic [CB-1:0] v = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        v[(r*D+c)*PW +: PW] = mdl_b[r][c];
    return v;
  endfunction

  task automatic model_clear();
    mdl_op = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++) begin
        mdl_a[r][c] = '0;
        mdl_b[r][c] = '0;
      end
  endtask

  task automatic model_issue(input logic [3:0] op, input bit lb);
    mdl_op = op;
    for (int k = 0; k < N; k++) begin
      mdl_a[k / D][k % D] = stim[k];
      if (lb) mdl_b[k / D][k % D] = stim[N + k];
    end
  endtask

  // One full instruction: command, pixel stream with random gaps, then an iw hold of 'hold' cycles.
  task automatic run_instr(input logic [3:0] op, input bit lb, input int stall_pct, input int hold);
    int n;
    int idx;
    int cyc;
    bit pv;
    n = lb ? 2*N : N;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_load_b = lb;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    // Keep offering a different command while busy; it must not be taken.
    cmd_opcode = ~op;
    cmd_load_b = !lb;
    check("busy_load", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      pv        = ($urandom_range(99) >= stall_pct);
      pix_valid = pv;
      pix_data  = pv ? stim[idx] : PW'($urandom);
      iw_ready  = 1'($urandom);
      if (pv && pix_ready) idx++;
      if (idx == n) check("iw_valid_before_last", iw_valid, 0);
      @(negedge clk);
      cyc++;
    end
    // A pixel offered during ISSUE must be left with the source.
    pix_valid = 1'b1;
    pix_data  = 24'hDEAD00;
    check("pixels_accepted", idx, n);
    if (stall_pct == 0) check("load_cycles", cyc, n);
    check("iw_valid_rise", iw_valid, 1);
    model_issue(op, lb);
    for (int h = 0; h < hold; h++) begin
      iw_ready = 1'b0;
      check("hold_iw_valid", iw_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_pix_ready", pix_ready, 0);
      check("hold_cell_a", iw_cell_a, pack_a());
      check("hold_cell_b", iw_cell_b, pack_b());
      @(negedge clk);
    end
    iw_ready = 1'b1;
    check("issue_valid", iw_valid, 1);
    check("issue_opcode", iw_opcode, mdl_op);
    check("issue_cell_a", iw_cell_a, pack_a());
    check("issue_cell_b", iw_cell_b, pack_b());
    @(negedge clk);
    iw_ready  = 1'b0;
    cmd_valid = 1'b0;
    pix_valid = 1'b0;
    check("post_iw_valid", iw_valid, 0);
    check("post_busy", busy, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iw_valid"}, iw_valid, 0);
    check({tag, "_opcode"}, iw_opcode, 0);
    check({tag, "_cell_a"}, iw_cell_a, 0);
    check({tag, "_cell_b"}, iw_cell_b, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_load_b = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    iw_ready   = 1'b0;
    model_clear();

    vecs[0] = '{4'h1, 1'b1, 24'h000000, 24'h000000, 24'h00FF00, 24'h000000, 0, 0,
                24'h000000, 24'h000000, 24'h00FF00, 24'h00FF00};
    vecs[1] = '{4'h2, 1'b0, 24'h000000, 24'h000001, 24'h000000, 24'h000000, 0, 5,
                24'h000000, 24'h00000F, 24'h00FF00, 24'h00FF00};
    vecs[2] = '{4'h3, 1'b1, 24'h100000, 24'h010101, 24'hABCDEF, 24'hFFFFFF, 50, 2,
                24'h100000, 24'h1F0F0F, 24'hABCDEF, 24'hABCDE0};
    vecs[3] = '{4'h2, 1'b0, 24'h000000, 24'h000001, 24'h000000, 24'h000000, 50, 1,
                24'h000000, 24'h00000F, 24'hABCDEF, 24'hABCDE0};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_cmd_ready", cmd_ready, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) begin
        stim[k]     = vecs[i].a_base + PW'(k) * vecs[i].a_step;
        stim[N + k] = vecs[i].b_base + PW'(k) * vecs[i].b_step;
      end
      run_instr(vecs[i].op, vecs[i].lb, vecs[i].stall, vecs[i].hold);
      check("vec_a00", iw_cell_a[0 +: PW], vecs[i].exp_a0);
      check("vec_a33", iw_cell_a[15*PW +: PW], vecs[i].exp_a15);
      check("vec_b00", iw_cell_b[0 +: PW], vecs[i].exp_b0);
      check("vec_b33", iw_cell_b[15*PW +: PW], vecs[i].exp_b15);
    end

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 2*N; k++) stim[k] = PW'($urandom);
      run_instr(4'($urandom), 1'($urandom), $urandom_range(0, 60), $urandom_range(0, 3));
    end

    // Reset after 7 cellA pixels: partial data discarded at once, next command starts at [0][0].
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = 4'h5;
    cmd_load_b = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      pix_valid = 1'b1;
      pix_data  = 24'h700000 + PW'(k);
      @(negedge clk);
    end
    check("mid_busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    @(negedge clk);
    pix_valid = 1'b0;
    reset_n   = 1'b1;
    for (int k = 0; k < N; k++) stim[k] = 24'h300000 + PW'(k);
    run_instr(4'h6, 1'b0, 0, 0);
    check("restart_a00", iw_cell_a[0 +: PW], 24'h300000);

`ifdef CELL_ASSEMBLER_PERF_EN
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    check("perf_issue_reset", perf_issue_cnt, 0);
    check("perf_stall_reset", perf_stall_cnt, 0);
    for (int k = 0; k < 2*N; k++) stim[k] = PW'($urandom);
    run_instr(4'h1, 1'b1, 0, 1);
    run_instr(4'h2, 1'b0, 0, 2);
    run_instr(4'h3, 1'b0, 0, 1);
    check("perf_issue_cnt", perf_issue_cnt, 3);
    check("perf_stall_cnt", perf_stall_cnt, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
